rs232_frame_ctrl: RTL and testbench

//  Frame controller between the serial receive engine and consumers. Takes the byte

---
 rtl/rs232_frame_ctrl_if.sv | 36 +++
 rtl/rs232_frame_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_rs232_frame_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// rs232_frame_ctrl_if
// Bundles the byte stream, the consumer handshake and the payload read port
// of the RS-232 frame controller.
//   master : the frame controller (consumes RData/DVPulse/FrameAck/RdAddr,
//            drives RdData, FrameRdy, FrameLen, Busy and the error pulses)
//   slave  : the receive engine / consumer side (the opposite directions)
// ---------------------------------------------------------------------------
interface rs232_frame_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]        RData;
    logic              DVPulse;
    logic              FrameAck;
    logic [ADDR_W-1:0] RdAddr;
    logic [7:0]        RdData;
    logic              FrameRdy;
    logic [7:0]        FrameLen;
    logic              Busy;
    logic              ErrChk;
    logic              ErrLen;
    logic              ErrTimeout;
    logic              ErrOverrun;

    modport master (
        input  RData, DVPulse, FrameAck, RdAddr,
        output RdData, FrameRdy, FrameLen, Busy,
               ErrChk, ErrLen, ErrTimeout, ErrOverrun
    );

    modport slave (
        output RData, DVPulse, FrameAck, RdAddr,
        input  RdData, FrameRdy, FrameLen, Busy,
               ErrChk, ErrLen, ErrTimeout, ErrOverrun
    );
endinterface

// File: rtl/rs232_frame_ctrl.sv
// ---------------------------------------------------------------------------
// rs232_frame_ctrl
// Frames the received byte stream as SYNC / LEN / PAYLOAD / CHK, buffers the
// payload and exposes it only once the XOR checksum matches. A verified
// frame is held until the consumer acknowledges it.
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active-high
//   bus  - rs232_frame_ctrl_if.master: RData/DVPulse byte stream, FrameAck,
//          RdAddr -> RdData (registered, 1 cycle), FrameRdy, FrameLen, Busy,
//          ErrChk/ErrLen/ErrTimeout/ErrOverrun single-cycle pulses
// ---------------------------------------------------------------------------
module rs232_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter logic [7:0] CHK_SEED    = 8'h5A,
    parameter int         MAX_LEN     = 16,
    parameter int         ADDR_W      = 4,
    parameter int         TIMEOUT_CYC = 10000
) (
    input  logic                 clk,
    input  logic                 rst,
    rs232_frame_ctrl_if.master   bus
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam int IDX_W = ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, HOLD} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [7:0]        r_acc;
    logic [7:0]        r_len;
    logic [7:0]        r_frameLen;
    logic [7:0]        r_rdData;
    logic [IDX_W-1:0]  r_idx;
    logic [TMO_W-1:0]  r_tmo;
    logic [7:0]        r_buf [2**ADDR_W];
    logic              r_errChk;
    logic              r_errLen;
    logic              r_errTimeout;
    logic              r_errOverrun;

    logic              w_errChk;
    logic              w_errLen;
    logic              w_errTimeout;
    logic              w_errOverrun;
    logic              w_timeout;
    logic              w_lastPayload;
    logic [IDX_W-1:0]  w_idxNext;
    logic              w_busy;
    logic              w_frameRdy;

    // idx is one bit wider than the buffer address so a full 2**ADDR_W frame
    // compares against len without wrapping.
    assign w_idxNext     = r_idx + IDX_W'(1);
    assign w_lastPayload = (8'(w_idxNext) == r_len);
    // A byte arriving in the same cycle as the limit wins over the timeout.
    assign w_timeout     = w_busy && !bus.DVPulse && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // Next-state and error decode.
    always_comb begin
        w_nextState  = r_state;
        w_errChk     = 1'b0;
        w_errLen     = 1'b0;
        w_errTimeout = 1'b0;
        w_errOverrun = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.DVPulse && bus.RData == SYNC_BYTE) w_nextState = LEN;
            end
            LEN: begin
                if (bus.DVPulse) begin
                    if (bus.RData > 8'(MAX_LEN)) begin
                        w_errLen    = 1'b1;
                        w_nextState = IDLE;
                    end else if (bus.RData == 8'h00) begin
                        w_nextState = CHK;
                    end else begin
                        w_nextState = PAYLOAD;
                    end
                end else if (w_timeout) begin
                    w_errTimeout = 1'b1;
                    w_nextState  = IDLE;
                end
            end
            PAYLOAD: begin
                if (bus.DVPulse) begin
                    if (w_lastPayload) w_nextState = CHK;
                end else if (w_timeout) begin
                    w_errTimeout = 1'b1;
                    w_nextState  = IDLE;
                end
            end
            CHK: begin
                if (bus.DVPulse) begin
                    if (bus.RData == r_acc) begin
                        w_nextState = HOLD;
                    end else begin
                        w_errChk    = 1'b1;
                        w_nextState = IDLE;
                    end
                end else if (w_timeout) begin
                    w_errTimeout = 1'b1;
                    w_nextState  = IDLE;
                end
            end
            HOLD: begin
                // A byte coinciding with the release is still discarded.
                if (bus.DVPulse)  w_errOverrun = 1'b1;
                if (bus.FrameAck) w_nextState  = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_busy     = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CHK);
        w_frameRdy = (r_state == HOLD);
    end

    // Checksum, length, index, timeout counter, read port and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= 8'h00;
            r_len        <= 8'h00;
            r_frameLen   <= 8'h00;
            r_idx        <= '0;
            r_tmo        <= '0;
            r_rdData     <= 8'h00;
            r_errChk     <= 1'b0;
            r_errLen     <= 1'b0;
            r_errTimeout <= 1'b0;
            r_errOverrun <= 1'b0;
        end else begin
            r_errChk     <= w_errChk;
            r_errLen     <= w_errLen;
            r_errTimeout <= w_errTimeout;
            r_errOverrun <= w_errOverrun;
            r_rdData     <= r_buf[bus.RdAddr];
            if (bus.DVPulse || r_state == IDLE || r_state == HOLD) r_tmo <= '0;
            else                                                   r_tmo <= r_tmo + TMO_W'(1);
            if (bus.DVPulse) begin
                unique case (r_state)
                    IDLE:    r_acc <= SYNC_BYTE ^ CHK_SEED;
                    LEN: begin
                        r_acc <= r_acc ^ bus.RData;
                        r_len <= bus.RData;
                        r_idx <= '0;
                    end
                    PAYLOAD: begin
                        r_acc <= r_acc ^ bus.RData;
                        r_idx <= w_idxNext;
                    end
                    CHK:     if (bus.RData == r_acc) r_frameLen <= r_len;
                    default: ;
                endcase
            end
        end
    end

    // Payload storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (r_state == PAYLOAD && bus.DVPulse) r_buf[r_idx[ADDR_W-1:0]] <= bus.RData;
    end

    assign bus.RdData     = r_rdData;
    assign bus.FrameRdy   = w_frameRdy;
    assign bus.FrameLen   = r_frameLen;
    assign bus.Busy       = w_busy;
    assign bus.ErrChk     = r_errChk;
    assign bus.ErrLen     = r_errLen;
    assign bus.ErrTimeout = r_errTimeout;
    assign bus.ErrOverrun = r_errOverrun;

endmodule

// File: tb/tb_rs232_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rs232_frame_ctrl
// Self-checking bench for rs232_frame_ctrl. Frames are built at the frame
// level (sync, length, payload, XOR checksum) and the expected outcome of
// each whole frame is derived from the framing rules, then checked byte by
// byte against the error pulses, FrameRdy/FrameLen and the payload readback.
// ---------------------------------------------------------------------------
module tb_rs232_frame_ctrl;

    localparam int         ADDR_W  = 4;
    localparam int         MAX_LEN = 16;
    localparam int         TMO     = 10000;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam logic [7:0] SEED    = 8'h5A;
    localparam logic [3:0] E_NONE  = 4'b0000;
    localparam logic [3:0] E_CHK   = 4'b1000;
    localparam logic [3:0] E_LEN   = 4'b0100;
    localparam logic [3:0] E_TMO   = 4'b0010;
    localparam logic [3:0] E_OVR   = 4'b0001;

    logic clk = 1'b0;
    logic rst;

    rs232_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    rs232_frame_ctrl #(
        .SYNC_BYTE  (SYNC),
        .CHK_SEED   (SEED),
        .MAX_LEN    (MAX_LEN),
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock; all driving and sampling happens on falling edges.
    always #10 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: what frame, if any, the controller should be holding.
    bit         held = 1'b0;
    logic [7:0] heldLen;
    logic [7:0] heldPayload[$];

    // Pending bytes of the current transaction with the error pulse each one
    // is expected to produce.
    logic [7:0] txQ[$];
    logic [3:0] expQ[$];

    logic [3:0] errs;
    assign errs = {bus.ErrChk, bus.ErrLen, bus.ErrTimeout, bus.ErrOverrun};

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Checksum as defined for the frame: seed ^ sync ^ len ^ every payload byte.
    function automatic logic [7:0] frameChk(input logic [7:0] len, input logic [7:0] pl[$]);
        logic [7:0] c;
        c = SEED ^ SYNC ^ len;
        foreach (pl[i]) c = c ^ pl[i];
        return c;
    endfunction

    function automatic logic [7:0] nonSyncByte();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h00;
        return b;
    endfunction

    // Drive one byte strobe starting at a falling edge and check the error
    // pulse it produces one edge later.
    task automatic sendByte(input logic [7:0] b, input logic [3:0] expErr);
        bus.RData   = b;
        bus.DVPulse = 1'b1;
        @(negedge clk);
        bus.DVPulse = 1'b0;
        checkOutput("errAfterByte", 32'(errs), 32'(expErr));
    endtask

    // Idle cycles; optionally confirm that no error pulse appears during them.
    task automatic idleCycles(input int n, input bit chkErr);
        logic [3:0] seen;
        seen = 4'b0000;
        repeat (n) begin
            @(negedge clk);
            seen = seen | errs;
        end
        if (n > 0 && chkErr) checkOutput("idleNoErr", 32'(seen), 32'(E_NONE));
    endtask

    task automatic pushByte(input logic [7:0] b, input logic [3:0] e);
        txQ.push_back(b);
        expQ.push_back(e);
    endtask

    // Send the queued transaction with gaps drawn from [minGap, maxGap].
    task automatic sendQueue(input int minGap, input int maxGap);
        foreach (txQ[i]) begin
            if (i > 0) idleCycles(int'($urandom_range(minGap, maxGap)), 1'b1);
            sendByte(txQ[i], expQ[i]);
        end
        txQ.delete();
        expQ.delete();
    endtask

    // Build one frame-level transaction and its expected outcome.
    //   kind 0: stray non-sync byte, 1-3: good frame, 4: bad checksum,
    //   5: oversized length. While a frame is held every byte overruns.
    task automatic applyStimulus(input int kind, input int maxGap);
        logic [7:0] len;
        logic [7:0] chk;
        logic [7:0] pl[$];
        logic [3:0] e;
        if (kind == 0) begin
            pushByte(nonSyncByte(), held ? E_OVR : E_NONE);
        end else if (kind == 5) begin
            len = 8'($urandom_range(MAX_LEN + 1, 255));
            pushByte(SYNC, held ? E_OVR : E_NONE);
            pushByte(len, held ? E_OVR : E_LEN);
        end else begin
            len = 8'($urandom_range(0, MAX_LEN));
            for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom_range(0, 255)));
            chk = frameChk(len, pl);
            if (kind == 4) chk = chk ^ 8'($urandom_range(1, 255));
            e = held ? E_OVR : E_NONE;
            pushByte(SYNC, e);
            pushByte(len, e);
            foreach (pl[i]) pushByte(pl[i], e);
            pushByte(chk, held ? E_OVR : ((kind == 4) ? E_CHK : E_NONE));
            if (!held && kind != 4) begin
                held        = 1'b1;
                heldLen     = len;
                heldPayload = pl;
            end
        end
        sendQueue(0, maxGap);
    endtask

    // Compare the controller's visible frame state against the model and
    // read the held payload back through the registered read port.
    task automatic verifyHeld();
        checkOutput("busyIdle", 32'(bus.Busy), 32'(0));
        checkOutput("frameRdy", 32'(bus.FrameRdy), 32'(held));
        if (held) begin
            checkOutput("frameLen", 32'(bus.FrameLen), 32'(heldLen));
            for (int i = 0; i < int'(heldLen); i++) begin
                bus.RdAddr = ADDR_W'(i);
                @(negedge clk);
                checkOutput("rdData", 32'(bus.RdData), 32'(heldPayload[i]));
            end
        end
    endtask

    // Release the held frame, optionally with a byte landing in the same cycle.
    task automatic doAck(input bit withByte);
        bus.FrameAck = 1'b1;
        if (withByte) begin
            bus.RData   = 8'h3C;
            bus.DVPulse = 1'b1;
        end
        @(negedge clk);
        bus.FrameAck = 1'b0;
        bus.DVPulse  = 1'b0;
        checkOutput("ackErr", 32'(errs), 32'((withByte && held) ? E_OVR : E_NONE));
        held = 1'b0;
        checkOutput("ackRelease", 32'(bus.FrameRdy), 32'(0));
    endtask

    // The fixed three-byte frame 11 22 33 with checksum FC.
    task automatic pushCase1();
        pushByte(SYNC,  E_NONE);
        pushByte(8'h03, E_NONE);
        pushByte(8'h11, E_NONE);
        pushByte(8'h22, E_NONE);
        pushByte(8'h33, E_NONE);
        pushByte(8'hFC, E_NONE);
        held        = 1'b1;
        heldLen     = 8'h03;
        heldPayload = '{8'h11, 8'h22, 8'h33};
    endtask

    // Main sequence: reset checks, directed frames, then randomized traffic.
    initial begin
        rst          = 1'b1;
        bus.RData    = 8'h00;
        bus.DVPulse  = 1'b0;
        bus.FrameAck = 1'b0;
        bus.RdAddr   = '0;
        #25;
        checkOutput("rstBusy",     32'(bus.Busy),     32'(0));
        checkOutput("rstFrameRdy", 32'(bus.FrameRdy), 32'(0));
        checkOutput("rstFrameLen", 32'(bus.FrameLen), 32'(0));
        checkOutput("rstRdData",   32'(bus.RdData),   32'(0));
        checkOutput("rstErrs",     32'(errs),         32'(E_NONE));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] good frame and readback");
        pushCase1();
        sendQueue(0, 0);
        verifyHeld();

        $display("[TB] overrun while holding, ack with coincident byte");
        pushByte(SYNC,  E_OVR);
        pushByte(8'h01, E_OVR);
        pushByte(8'h77, E_OVR);
        pushByte(8'h89, E_OVR);
        sendQueue(0, 2);
        verifyHeld();
        doAck(1'b1);
        verifyHeld();

        $display("[TB] bad checksum then good frame");
        pushByte(SYNC,  E_NONE);
        pushByte(8'h03, E_NONE);
        pushByte(8'h11, E_NONE);
        pushByte(8'h22, E_NONE);
        pushByte(8'h33, E_NONE);
        pushByte(8'hFD, E_CHK);
        sendQueue(0, 0);
        @(negedge clk);
        checkOutput("chkPulseWidth", 32'(errs), 32'(E_NONE));
        verifyHeld();
        pushCase1();
        sendQueue(0, 0);
        verifyHeld();
        doAck(1'b0);

        $display("[TB] inter-byte timeout and its boundary");
        sendByte(SYNC,  E_NONE);
        sendByte(8'h03, E_NONE);
        sendByte(8'h11, E_NONE);
        idleCycles(TMO - 1, 1'b1);
        checkOutput("busyBeforeTmo", 32'(bus.Busy), 32'(1));
        @(negedge clk);
        checkOutput("tmoPulse", 32'(errs), 32'(E_TMO));
        checkOutput("tmoBusy",  32'(bus.Busy), 32'(0));
        @(negedge clk);
        checkOutput("tmoPulseWidth", 32'(errs), 32'(E_NONE));
        pushCase1();
        sendQueue(TMO - 1, TMO - 1);
        verifyHeld();
        doAck(1'b0);

        $display("[TB] length limits");
        pushByte(SYNC,  E_NONE);
        pushByte(8'h20, E_LEN);
        sendQueue(0, 0);
        pushByte(SYNC,  E_NONE);
        pushByte(8'h11, E_LEN);
        sendQueue(0, 0);
        verifyHeld();
        pushByte(SYNC,  E_NONE);
        pushByte(8'h00, E_NONE);
        pushByte(8'hFF, E_NONE);
        held    = 1'b1;
        heldLen = 8'h00;
        heldPayload.delete();
        sendQueue(0, 0);
        verifyHeld();
        doAck(1'b0);
        doAck(1'b0);

        $display("[TB] asynchronous reset mid-frame");
        sendByte(SYNC,  E_NONE);
        sendByte(8'h03, E_NONE);
        sendByte(8'h11, E_NONE);
        #3 rst = 1'b1;
        #1;
        checkOutput("asyncRstBusy", 32'(bus.Busy),     32'(0));
        checkOutput("asyncRstRdy",  32'(bus.FrameRdy), 32'(0));
        checkOutput("asyncRstErrs", 32'(errs),         32'(E_NONE));
        @(negedge clk);
        rst  = 1'b0;
        held = 1'b0;
        @(negedge clk);
        pushCase1();
        sendQueue(0, 1);
        verifyHeld();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 80; n++) begin
            int kind;
            kind = int'($urandom_range(0, 6));
            if (kind == 6) doAck($urandom_range(0, 1) == 1);
            else           applyStimulus(kind, 3);
            verifyHeld();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Absolute time limit in case the sequence above stalls.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        errorCount++;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
